// File: rtl/lsu_region_router_if.sv
// LSU-side request/response and region-side bus bundle for lsu_region_router.
// The router takes the slave modport; the LSU/region model side takes master.
interface lsu_region_router_if #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned NUM_REGIONS = 4
);
  logic                      i_req_valid;
  logic                      o_req_ready;
  logic [ADDR_W-1:0]         i_req_addr;
  logic                      i_req_we;
  logic [1:0]                i_req_size;
  logic [31:0]               i_req_wdata;
  logic [NUM_REGIONS-1:0]    o_rgn_sel;
  logic                      o_rgn_we;
  logic [ADDR_W-1:0]         o_rgn_addr;
  logic [3:0]                o_rgn_be;
  logic [31:0]               o_rgn_wdata;
  logic [NUM_REGIONS-1:0]    i_rgn_ack;
  logic [NUM_REGIONS*32-1:0] i_rgn_rdata;
  logic                      o_rsp_valid;
  logic [31:0]               o_rsp_rdata;
  logic                      o_rsp_err;

  modport master (
    output i_req_valid, i_req_addr, i_req_we, i_req_size, i_req_wdata, i_rgn_ack, i_rgn_rdata,
    input  o_req_ready, o_rgn_sel, o_rgn_we, o_rgn_addr, o_rgn_be, o_rgn_wdata,
           o_rsp_valid, o_rsp_rdata, o_rsp_err
  );

  modport slave (
    input  i_req_valid, i_req_addr, i_req_we, i_req_size, i_req_wdata, i_rgn_ack, i_rgn_rdata,
    output o_req_ready, o_rgn_sel, o_rgn_we, o_rgn_addr, o_rgn_be, o_rgn_wdata,
           o_rsp_valid, o_rsp_rdata, o_rsp_err
  );
endinterface

// File: rtl/lsu_region_router.sv
// Single-outstanding LSU-to-region router: region decode, byte enables, error responses.
// Optional ack watchdog enabled by defining ROUTER_TIMEOUT_EN.
module lsu_region_router #(
  parameter int unsigned            ADDR_W         = 32,
  parameter int unsigned            NUM_REGIONS    = 4,
  parameter int unsigned            SEL_LSB        = 8,
  parameter logic [NUM_REGIONS-1:0] REGION_EN      = 4'b0110,
  parameter int unsigned            TIMEOUT_CYCLES = 16
) (
  input logic                i_clk,
  input logic                i_rst,
  lsu_region_router_if.slave bus
);
  localparam int unsigned SEL_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
  localparam int unsigned HI_LSB = SEL_LSB + SEL_W;
  localparam logic [ADDR_W-1:0] HI_MASK =
      (HI_LSB >= ADDR_W) ? '0 : ({ADDR_W{1'b1}} << HI_LSB);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [SEL_W-1:0]  idx_q, idx_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [SEL_W-1:0]  req_idx;
  logic              rgn_on, unmapped, misaligned, bad_size, req_err;
  logic [3:0]        req_be;
  logic [31:0]       req_wdata;
  logic              ack_hit;
  logic [31:0]       rgn_rdata;

  // Request decode, evaluated against the live request in IDLE.
  always_comb begin
    req_idx = bus.i_req_addr[SEL_LSB +: SEL_W];
    rgn_on  = 1'b0;
    for (int unsigned r = 0; r < NUM_REGIONS; r++) begin
      if (req_idx == SEL_W'(r) && REGION_EN[r]) rgn_on = 1'b1;
    end
    unmapped   = ((bus.i_req_addr & HI_MASK) != '0) || !rgn_on;
    misaligned = (bus.i_req_size == 2'b01 && bus.i_req_addr[0]) ||
                 (bus.i_req_size == 2'b10 && bus.i_req_addr[1:0] != 2'b00);
    bad_size   = (bus.i_req_size == 2'b11);
    req_err    = unmapped || misaligned || bad_size;

    case (bus.i_req_size)
      2'b00: begin
        req_be    = 4'b0001 << bus.i_req_addr[1:0];
        req_wdata = {4{bus.i_req_wdata[7:0]}};
      end
      2'b01: begin
        req_be    = 4'b0011 << bus.i_req_addr[1:0];
        req_wdata = {2{bus.i_req_wdata[15:0]}};
      end
      default: begin
        req_be    = 4'b1111;
        req_wdata = bus.i_req_wdata;
      end
    endcase
    if (!bus.i_req_we) req_be = 4'b1111;
  end

  // Only the selected region's ack and read word matter.
  always_comb begin
    ack_hit   = 1'b0;
    rgn_rdata = '0;
    for (int unsigned r = 0; r < NUM_REGIONS; r++) begin
      if (idx_q == SEL_W'(r)) begin
        ack_hit   = bus.i_rgn_ack[r];
        rgn_rdata = bus.i_rgn_rdata[r*32 +: 32];
      end
    end
  end

`ifdef ROUTER_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    idx_d   = idx_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
`ifdef ROUTER_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.i_req_valid) begin
          addr_d  = bus.i_req_addr;
          we_d    = bus.i_req_we;
          idx_d   = req_idx;
          be_d    = req_be;
          wdata_d = req_wdata;
          rdata_d = '0;
          err_d   = req_err;
          state_d = req_err ? StResp : StAccess;
`ifdef ROUTER_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      StAccess: begin
        if (ack_hit) begin
          rdata_d = we_q ? 32'h0 : rgn_rdata;
          err_d   = 1'b0;
          state_d = StResp;
        end
`ifdef ROUTER_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Region bus is driven only in ACCESS, response fields only in RESP.
  always_comb begin
    bus.o_req_ready = (state_q == StIdle);
    for (int unsigned r = 0; r < NUM_REGIONS; r++) begin
      bus.o_rgn_sel[r] = (state_q == StAccess) && (idx_q == SEL_W'(r));
    end
    bus.o_rgn_we    = (state_q == StAccess) && we_q;
    bus.o_rgn_addr  = (state_q == StAccess) ? addr_q  : '0;
    bus.o_rgn_be    = (state_q == StAccess) ? be_q    : '0;
    bus.o_rgn_wdata = (state_q == StAccess) ? wdata_q : '0;
    bus.o_rsp_valid = (state_q == StResp);
    bus.o_rsp_rdata = (state_q == StResp) ? rdata_q : '0;
    bus.o_rsp_err   = (state_q == StResp) && err_q;
  end
endmodule

// File: tb/tb_lsu_region_router.sv
// Directed table-driven bench for lsu_region_router plus hand-written corner sequences.
module tb_lsu_region_router;
  localparam int unsigned TO = 16;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  lsu_region_router_if #(.ADDR_W(32), .NUM_REGIONS(4)) bus ();

  lsu_region_router #(
    .ADDR_W(32), .NUM_REGIONS(4), .SEL_LSB(8), .REGION_EN(4'b0110), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [1:0]  size;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] rd;
    logic        err;
    logic [3:0]  sel;
    logic [3:0]  be;
    logic [31:0] ewd;
    logic [31:0] erd;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] mk_rdata(input logic [3:0] sel, input logic [31:0] d);
    logic [127:0] v;
    for (int r = 0; r < 4; r++) v[r*32 +: 32] = sel[r] ? d : (32'hBAD0_0000 | 32'(r));
    return v;
  endfunction

  task automatic issue(input logic [31:0] a, input logic we, input logic [1:0] sz,
                       input logic [31:0] wd);
    bus.i_req_valid = 1'b1;
    bus.i_req_addr  = a;
    bus.i_req_we    = we;
    bus.i_req_size  = sz;
    bus.i_req_wdata = wd;
  endtask

  task automatic run_vec(input vec_t v);
    issue(v.addr, v.we, v.size, v.wdata);
    chk("ready_idle", 32'(bus.o_req_ready), 32'd1);
    step();
    bus.i_req_valid = 1'b0;
    if (v.err) begin
      chk("err_sel", 32'(bus.o_rgn_sel), 32'd0);
      chk("err_we", 32'(bus.o_rgn_we), 32'd0);
      chk("err_rsp_valid", 32'(bus.o_rsp_valid), 32'd1);
      chk("err_flag", 32'(bus.o_rsp_err), 32'd1);
      chk("err_rdata", bus.o_rsp_rdata, 32'd0);
    end else begin
      for (int w = 0; w <= v.waits; w++) begin
        chk("acc_sel", 32'(bus.o_rgn_sel), 32'(v.sel));
        chk("acc_be", 32'(bus.o_rgn_be), 32'(v.be));
        chk("acc_wdata", bus.o_rgn_wdata, v.ewd);
        chk("acc_we", 32'(bus.o_rgn_we), 32'(v.we));
        chk("acc_addr", bus.o_rgn_addr, v.addr);
        chk("acc_rsp_idle", 32'(bus.o_rsp_valid), 32'd0);
        chk("acc_ready", 32'(bus.o_req_ready), 32'd0);
        bus.i_rgn_rdata = mk_rdata(v.sel, v.rd);
        if (w == v.waits) bus.i_rgn_ack = v.sel;
        step();
      end
      bus.i_rgn_ack = '0;
      chk("rsp_valid", 32'(bus.o_rsp_valid), 32'd1);
      chk("rsp_err", 32'(bus.o_rsp_err), 32'd0);
      chk("rsp_rdata", bus.o_rsp_rdata, v.erd);
      chk("rsp_sel_low", 32'(bus.o_rgn_sel), 32'd0);
    end
    step();
    chk("post_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
    chk("post_ready", 32'(bus.o_req_ready), 32'd1);
    chk("post_rdata", bus.o_rsp_rdata, 32'd0);
  endtask

  initial begin
    //          addr      we    sz     wdata        w  rd            err   sel      be       ewd           erd
    vecs[0]  = '{32'h104, 1'b0, 2'b10, 32'h0,       0, 32'hDEADBEEF, 1'b0, 4'b0010, 4'b1111, 32'h0,        32'hDEADBEEF};
    vecs[1]  = '{32'h203, 1'b1, 2'b00, 32'hA5,      3, 32'h12345678, 1'b0, 4'b0100, 4'b1000, 32'hA5A5A5A5, 32'h0};
    vecs[2]  = '{32'h102, 1'b1, 2'b01, 32'h1234BEEF,1, 32'h0F0F0F0F, 1'b0, 4'b0010, 4'b1100, 32'hBEEFBEEF, 32'h0};
    vecs[3]  = '{32'h201, 1'b0, 2'b00, 32'h0,       2, 32'h55AA55AA, 1'b0, 4'b0100, 4'b1111, 32'h0,        32'h55AA55AA};
    vecs[4]  = '{32'h1FC, 1'b1, 2'b10, 32'h01234567,0, 32'h0,        1'b0, 4'b0010, 4'b1111, 32'h01234567, 32'h0};
    vecs[5]  = '{32'h202, 1'b0, 2'b01, 32'h0,       1, 32'hA1B2C3D4, 1'b0, 4'b0100, 4'b1111, 32'h0,        32'hA1B2C3D4};
    vecs[6]  = '{32'h004, 1'b0, 2'b10, 32'h0,       0, 32'h0,        1'b1, 4'b0000, 4'b0000, 32'h0,        32'h0};
    vecs[7]  = '{32'h300, 1'b0, 2'b10, 32'h0,       0, 32'h0,        1'b1, 4'b0000, 4'b0000, 32'h0,        32'h0};
    vecs[8]  = '{32'h1000,1'b0, 2'b10, 32'h0,       0, 32'h0,        1'b1, 4'b0000, 4'b0000, 32'h0,        32'h0};
    vecs[9]  = '{32'h101, 1'b0, 2'b01, 32'h0,       0, 32'h0,        1'b1, 4'b0000, 4'b0000, 32'h0,        32'h0};
    vecs[10] = '{32'h100, 1'b0, 2'b11, 32'h0,       0, 32'h0,        1'b1, 4'b0000, 4'b0000, 32'h0,        32'h0};
    vecs[11] = '{32'h102, 1'b1, 2'b10, 32'h11223344,0, 32'h0,        1'b1, 4'b0000, 4'b0000, 32'h0,        32'h0};
    vecs[12] = '{32'h2203,1'b1, 2'b00, 32'h77,      0, 32'h0,        1'b1, 4'b0000, 4'b0000, 32'h0,        32'h0};

    rst             = 1'b1;
    bus.i_req_valid = 1'b0;
    bus.i_req_addr  = '0;
    bus.i_req_we    = 1'b0;
    bus.i_req_size  = 2'b00;
    bus.i_req_wdata = '0;
    bus.i_rgn_ack   = '0;
    bus.i_rgn_rdata = '0;
    step();
    step();
    chk("rst_ready", 32'(bus.o_req_ready), 32'd1);
    chk("rst_sel", 32'(bus.o_rgn_sel), 32'd0);
    chk("rst_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
    rst = 1'b0;
    step();
    chk("idle_ready", 32'(bus.o_req_ready), 32'd1);
    chk("idle_be", 32'(bus.o_rgn_be), 32'd0);
    chk("idle_addr", bus.o_rgn_addr, 32'd0);
    chk("idle_err", 32'(bus.o_rsp_err), 32'd0);

    for (int i = 0; i < 13; i++) run_vec(vecs[i]);

    // Reset in the middle of an access drops it; idle acks are ignored.
    issue(32'h108, 1'b0, 2'b10, 32'h0);
    step();
    bus.i_req_valid = 1'b0;
    chk("mid_sel", 32'(bus.o_rgn_sel), 32'h2);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_sel", 32'(bus.o_rgn_sel), 32'd0);
    chk("mid_rst_ready", 32'(bus.o_req_ready), 32'd1);
    chk("mid_rst_be", 32'(bus.o_rgn_be), 32'd0);
    chk("mid_rst_addr", bus.o_rgn_addr, 32'd0);
    chk("mid_rst_rsp", 32'(bus.o_rsp_valid), 32'd0);
    step();
    rst           = 1'b0;
    bus.i_rgn_ack = 4'b0010;
    bus.i_rgn_rdata = mk_rdata(4'b0010, 32'h99999999);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("post_rst_rsp", 32'(bus.o_rsp_valid), 32'd0);
      chk("post_rst_ready", 32'(bus.o_req_ready), 32'd1);
    end
    bus.i_rgn_ack = '0;
    run_vec(vecs[0]);

    // Spurious ack from region 2 during a region-1 access.
    issue(32'h104, 1'b0, 2'b10, 32'h0);
    step();
    bus.i_req_valid = 1'b0;
    bus.i_rgn_rdata = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};
    bus.i_rgn_ack   = 4'b0100;
    step();
    chk("spur_sel", 32'(bus.o_rgn_sel), 32'h2);
    chk("spur_rsp", 32'(bus.o_rsp_valid), 32'd0);
    bus.i_rgn_ack = 4'b0010;
    step();
    bus.i_rgn_ack = '0;
    chk("spur_rsp_valid", 32'(bus.o_rsp_valid), 32'd1);
    chk("spur_rdata", bus.o_rsp_rdata, 32'h11111111);
    step();

    // A request held through RESP is taken only in the next IDLE cycle.
    issue(32'h004, 1'b0, 2'b10, 32'h0);
    step();
    chk("b2b_err_rsp", 32'(bus.o_rsp_valid), 32'd1);
    chk("b2b_resp_ready", 32'(bus.o_req_ready), 32'd0);
    issue(32'h104, 1'b0, 2'b10, 32'h0);
    bus.i_rgn_ack = 4'b0010;
    step();
    chk("b2b_idle_ready", 32'(bus.o_req_ready), 32'd1);
    chk("b2b_idle_sel", 32'(bus.o_rgn_sel), 32'd0);
    chk("b2b_idle_rsp", 32'(bus.o_rsp_valid), 32'd0);
    bus.i_rgn_ack = '0;
    step();
    bus.i_req_valid = 1'b0;
    chk("b2b_sel", 32'(bus.o_rgn_sel), 32'h2);
    bus.i_rgn_rdata = mk_rdata(4'b0010, 32'hC0FFEE00);
    bus.i_rgn_ack   = 4'b0010;
    step();
    bus.i_rgn_ack = '0;
    chk("b2b_rdata", bus.o_rsp_rdata, 32'hC0FFEE00);
    chk("b2b_err", 32'(bus.o_rsp_err), 32'd0);
    step();

`ifdef ROUTER_TIMEOUT_EN
    // No ack: sel high for TO+1 cycles, then error response.
    issue(32'h104, 1'b0, 2'b10, 32'h0);
    step();
    bus.i_req_valid = 1'b0;
    for (int k = 0; k <= int'(TO); k++) begin
      chk("to_sel", 32'(bus.o_rgn_sel), 32'h2);
      chk("to_rsp_idle", 32'(bus.o_rsp_valid), 32'd0);
      step();
    end
    chk("to_rsp_valid", 32'(bus.o_rsp_valid), 32'd1);
    chk("to_err", 32'(bus.o_rsp_err), 32'd1);
    chk("to_rdata", bus.o_rsp_rdata, 32'd0);
    chk("to_sel_low", 32'(bus.o_rgn_sel), 32'd0);
    step();
    // Ack on the limit cycle wins.
    issue(32'h104, 1'b0, 2'b10, 32'h0);
    step();
    bus.i_req_valid = 1'b0;
    bus.i_rgn_rdata = mk_rdata(4'b0010, 32'h5EED5EED);
    for (int k = 0; k <= int'(TO); k++) begin
      if (k == int'(TO)) bus.i_rgn_ack = 4'b0010;
      step();
    end
    bus.i_rgn_ack = '0;
    chk("to_ack_rsp", 32'(bus.o_rsp_valid), 32'd1);
    chk("to_ack_err", 32'(bus.o_rsp_err), 32'd0);
    chk("to_ack_rdata", bus.o_rsp_rdata, 32'h5EED5EED);
    step();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lsu_region_router.md
Name: lsu_region_router

Overview:
- Parametrised load/store region router between the core's LSU and N memory-mapped regions (instruction/boot, data memory, IO, ...).
- Decodes the region from address bits, generates byte enables for sub-word stores, and runs a single-outstanding valid/ack handshake that tolerates region wait states.
- Returns the read word and flags unmapped, disabled or misaligned accesses as error responses instead of silently dropping them.

Parameters:
- ADDR_W, 32, LSU address width.
- NUM_REGIONS, 4, number of regions; SEL_W = $clog2(NUM_REGIONS).
- SEL_LSB, 8, lowest address bit of the region index (0x100-byte regions).
- REGION_EN, 4'b0110, per-region enable mask; a cleared bit makes that region unmapped.
- TIMEOUT_CYCLES, 16, ack watchdog limit; used only with ROUTER_TIMEOUT_EN.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_req_valid  in  1  LSU request valid
- o_req_ready  out  1  router idle, can accept a request
- i_req_addr  in  ADDR_W  byte address
- i_req_we  in  1  1 = store, 0 = load
- i_req_size  in  2  00 byte, 01 half, 10 word; 11 is illegal
- i_req_wdata  in  32  store data, right-aligned
- o_rgn_sel  out  NUM_REGIONS  one-hot region request
- o_rgn_we  out  1  store strobe qualifier
- o_rgn_addr  out  ADDR_W  latched address
- o_rgn_be  out  4  byte enables
- o_rgn_wdata  out  32  lane-replicated store data
- i_rgn_ack  in  NUM_REGIONS  per-region completion
- i_rgn_rdata  in  NUM_REGIONS*32  per-region read words, concatenated
- o_rsp_valid  out  1  one-cycle response pulse
- o_rsp_rdata  out  32  read word; 0 for stores and errors
- o_rsp_err  out  1  error response

Behaviour:
- Reset: FSM goes to IDLE. All outputs are 0 except o_req_ready = 1. A reset asserted mid-access drops the transaction; no response is produced.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: o_req_ready = 1. When i_req_valid is high, latch addr/we/size/wdata and compute idx = addr[SEL_LSB +: SEL_W].
- Error conditions, checked in IDLE:
  - unmapped: any addr bit at or above SEL_LSB+SEL_W is nonzero, or idx >= NUM_REGIONS, or REGION_EN[idx] = 0;
  - misaligned: half with addr[0] = 1, or word with addr[1:0] != 0;
  - illegal size: size = 11.
- Any error -> RESP with err = 1; no region strobe is ever raised. Otherwise -> ACCESS.
- Byte enables:
  - byte: be = 1 << addr[1:0];
  - half: be = 0011 << addr[1:0];
  - word: be = 1111.
- Store data: wdata is replicated to all lanes (byte x4, half x2). Loads drive be = 1111.
- ACCESS: o_rgn_sel[idx] = 1, and sel/we/addr/be/wdata are held stable until i_rgn_ack[idx] = 1. On ack, capture the rdata slice [idx*32 +: 32] for loads (0 for stores), then -> RESP. Acks on non-selected regions are ignored.
- RESP: o_rsp_valid = 1 for exactly one cycle, then -> IDLE. There is no response backpressure. o_rsp_rdata and o_rsp_err are valid only while o_rsp_valid = 1 and are 0 otherwise.
- Latency, with the request accepted at cycle T:
  - zero-wait ack: sel at T+1, ack at T+1, rsp_valid at T+2;
  - each wait cycle adds 1;
  - error response: rsp_valid at T+1.
- o_req_ready is low in ACCESS and RESP, so a request arriving during RESP is accepted only in the following IDLE cycle.
- i_rgn_ack during IDLE or RESP is ignored.

Optional Feature:
- Macro: ROUTER_TIMEOUT_EN.
- Defined: a counter clears on ACCESS entry and increments each ACCESS cycle without ack. When the count reaches TIMEOUT_CYCLES with no ack, sel drops and the FSM goes to RESP with err = 1, rdata = 0. An ack arriving in the same cycle as the limit wins (normal response).
- Not defined: no counter; ACCESS waits indefinitely for ack.

Test Plan:
- Word load 0x104, region 1 acks immediately with rdata 0xDEADBEEF -> sel = 0010 at T+1, rsp_valid at T+2, rdata = 0xDEADBEEF, err = 0.
- Byte store 0x203, wdata 0x000000A5, region 2 acks after 3 wait cycles -> be = 1000, wdata = 0xA5A5A5A5 held stable 4 cycles, rsp at T+5, rdata = 0.
- Load 0x004 (region 0 disabled), load 0x1000 (upper bits set), half load 0x101, size 11 -> each gives rsp_valid at T+1 with err = 1 and o_rgn_sel = 0 throughout.
- Reset asserted while in ACCESS for 0x108 -> all outputs 0 immediately, o_req_ready = 1, no rsp_valid after reset release; next request completes normally.
- Spurious i_rgn_ack[2] during a region-1 access, then ack[1] -> transaction completes only on ack[1] with region 1's data.
- With ROUTER_TIMEOUT_EN, region never acks -> rsp_valid with err = 1 exactly TIMEOUT_CYCLES+1 cycles after sel rises; with ack on the limit cycle -> normal response.
